// File: rtl/umi_crossbar_arbiter.sv
// umi_crossbar_arbiter
//   Control stage ahead of the UMI crossbar. Each output port has its own
//   round-robin arbiter. The arbiter picks one requesting input and drives a
//   one-hot column of the select matrix. If the downstream port stalls a
//   granted beat, the grant is held until that beat transfers.
//
// Ports
//   clk         clock
//   nreset      async active-low reset
//   in_valid    [N]    input j has a transaction pending
//   in_request  [N*N]  bit [i*N+j]: input j targets output i
//   in_ready    [N]    input j accepted this cycle
//   out_valid   [N]    output i carries a valid transaction
//   out_ready   [N]    downstream of output i can accept
//   sel         [N*N]  one-hot grant per output; [i*N+:N] selects input for output i
//
// Per-output hold state
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_OPEN | no pending beat; arbitrate from ptr each cycle
//   ST_HOLD | granted beat stalled; grant frozen to gnt_q until transfer

module umi_crossbar_arbiter #(
   parameter        TARGET  = "DEFAULT",
   parameter int    N       = 4,
   parameter        ARBMODE = "ROUNDROBIN"
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic [N-1:0]     in_valid,
   input  logic [N*N-1:0]   in_request,
   output logic [N-1:0]     in_ready,
   output logic [N-1:0]     out_valid,
   input  logic [N-1:0]     out_ready,
   output logic [N*N-1:0]   sel
);

   localparam int PW        = (N > 1) ? $clog2(N) : 1;
   localparam bit FIXED_PRI = (ARBMODE == "FIXED");

   typedef enum logic {
      ST_OPEN = 1'b0,
      ST_HOLD = 1'b1
   } hold_state_t;

   // Per-output contribution to in_ready, flattened like sel.
   logic [N*N-1:0] rdy_flat;

   for (genvar i = 0; i < N; i++) begin : g_out
      hold_state_t     state, state_nxt;
      logic [PW-1:0]   ptr, ptr_nxt, start, gnt_idx, ptr_inc;
      logic [N-1:0]    gnt_q, gnt_q_nxt;
      logic [N-1:0]    req, gnt, gnt_rr;
      logic [N-1:0]    rot_req, rot_gnt;
      logic [2*N-1:0]  req_dbl, gnt_dbl;
      logic            vld;

      assign req   = in_request[i*N +: N] & in_valid;
      assign start = FIXED_PRI ? '0 : ptr;

      // Rotate so the priority input sits at bit 0, pick the lowest set
      // bit, then rotate back. The doubled vector provides the wrap.
      assign req_dbl = {req, req} >> start;
      assign rot_req = req_dbl[N-1:0];
      assign rot_gnt = rot_req & (-rot_req);
      assign gnt_dbl = {rot_gnt, rot_gnt} << start;
      assign gnt_rr  = gnt_dbl[2*N-1:N];

      // A held grant is masked with the live request so that a dropped
      // in_valid deasserts out_valid instead of forwarding a stale beat.
      assign gnt = (state == ST_HOLD) ? (gnt_q & req) : gnt_rr;
      assign vld = |gnt;

      always_comb begin
         gnt_idx = '0;
         for (int k = 0; k < N; k++) begin
            if (gnt[k]) gnt_idx = PW'(k);
         end
      end

      assign ptr_inc = (gnt_idx == PW'(N-1)) ? '0 : gnt_idx + PW'(1);

      always_comb begin
         state_nxt = state;
         ptr_nxt   = ptr;
         gnt_q_nxt = gnt_q;
         if (vld && !out_ready[i]) begin
            state_nxt = ST_HOLD;
            gnt_q_nxt = gnt;
         end else if (vld) begin
            state_nxt = ST_OPEN;
            gnt_q_nxt = '0;
            if (!FIXED_PRI) ptr_nxt = ptr_inc;
         end else begin
            state_nxt = ST_OPEN;
            gnt_q_nxt = '0;
         end
      end

      always_ff @(posedge clk or negedge nreset) begin
         if (!nreset) begin
            state <= ST_OPEN;
            ptr   <= '0;
            gnt_q <= '0;
         end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            gnt_q <= gnt_q_nxt;
         end
      end

      assign sel[i*N +: N]      = gnt;
      assign out_valid[i]       = vld;
      assign rdy_flat[i*N +: N] = gnt & {N{out_ready[i]}};
   end

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < N; i++) begin
         in_ready = in_ready | rdy_flat[i*N +: N];
      end
   end

endmodule
